// File: rtl/rtc_alarm.sv
// rtc_alarm: memory-mapped alarm peripheral downstream of the RTC up-counter.
//   Compares the live month/day/hour/min/sec against a programmed alarm under a
//   field mask. On each rising edge of a match it latches a pending flag, a time
//   snapshot and a saturating match count, and raises a level interrupt.
// Optional feature macro: RTC_ALARM_SNOOZE_EN (snooze re-arm on seconds ticks).
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   cs, wr            peripheral select, write strobe
//   addr[31:0]        byte address, addr[3:2] selects CTRL/ALARM/STATUS/SNAP
//   wdata[31:0]       write data
//   rdata[31:0]       combinational read data for addr[3:2]
//   sec/min/hour/day/month  live time from the RTC counter
//   irq               PEND & IE
module rtc_alarm #(
  parameter int unsigned CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [5:0]  sec,
  input  logic [5:0]  min,
  input  logic [4:0]  hour,
  input  logic [4:0]  day,
  input  logic [3:0]  month,
  output logic        irq
);

  localparam int unsigned TIME_W = 26;
  localparam int unsigned SNZ_W  = 8;
  localparam logic [1:0]  REG_CTRL   = 2'd0;
  localparam logic [1:0]  REG_ALARM  = 2'd1;
  localparam logic [1:0]  REG_STATUS = 2'd2;
  localparam logic [1:0]  REG_SNAP   = 2'd3;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    SNOOZING = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                en_d, snz_d;
  logic                ie_q, oneshot_q, pend_q, match_q;
  logic [4:0]          mask_q;
  logic [TIME_W-1:0]   alarm_q, snap_q, time_now;
  logic [CNT_W-1:0]    count_q;
  logic [SNZ_W-1:0]    snooze_q;
  logic [1:0]          reg_sel;
  logic                bus_we, ctrl_we, alarm_we, status_we;
  logic                en, snoozing;
  logic [4:0]          field_eq;
  logic                match_now, event_c, snz_cmd, snz_expire;
  logic                unused_ok;

  // Bus decode
  assign reg_sel   = addr[3:2];
  assign bus_we    = cs & wr;
  assign ctrl_we   = bus_we & (reg_sel == REG_CTRL);
  assign alarm_we  = bus_we & (reg_sel == REG_ALARM);
  assign status_we = bus_we & (reg_sel == REG_STATUS);

  assign en       = (state_q != DISARMED);
  assign snoozing = (state_q == SNOOZING);

  // Live time in ALARM register packing
  assign time_now = {month, day, hour, min, sec};

  // Per-field compare, bit order matches MASK {month,day,hour,min,sec}
  assign field_eq[0] = (sec   == alarm_q[5:0]);
  assign field_eq[1] = (min   == alarm_q[11:6]);
  assign field_eq[2] = (hour  == alarm_q[16:12]);
  assign field_eq[3] = (day   == alarm_q[21:17]);
  assign field_eq[4] = (month == alarm_q[25:22]);

  assign match_now = en & (|mask_q) & (&(field_eq | ~mask_q));
  assign event_c   = match_now & ~match_q;

`ifdef RTC_ALARM_SNOOZE_EN
  logic [SNZ_W-1:0] snz_cnt_q;
  logic [5:0]       sec_q;
  logic             sec_tick;

  assign sec_tick   = (sec != sec_q);
  // A coincident alarm event wins over the snooze command
  assign snz_cmd    = status_we & wdata[2] & pend_q & (snooze_q != '0) & en & ~event_c;
  assign snz_expire = snoozing & sec_tick & (snz_cnt_q == SNZ_W'(1));

  // Snooze reload value and seconds countdown
  always_ff @(posedge clk) begin
    if (!reset) begin
      snooze_q  <= '0;
      snz_cnt_q <= '0;
      sec_q     <= '0;
    end else begin
      sec_q <= sec;
      if (ctrl_we) snooze_q <= wdata[15:8];
      if (snz_cmd) begin
        snz_cnt_q <= snooze_q;
      end else if (snoozing & sec_tick & (snz_cnt_q != '0)) begin
        snz_cnt_q <= snz_cnt_q - SNZ_W'(1);
      end
    end
  end
`else
  assign snooze_q   = '0;
  assign snz_cmd    = 1'b0;
  assign snz_expire = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= DISARMED;
    else        state_q <= state_d;
  end

  // FSM next state: a CTRL write overrides the one-shot auto-disable
  always_comb begin
    en_d    = en;
    snz_d   = snoozing;
    state_d = state_q;
    if (event_c & oneshot_q)   en_d  = 1'b0;
    if (ctrl_we)               en_d  = wdata[0];
    if (snz_cmd)               snz_d = 1'b1;
    if (snz_expire | event_c)  snz_d = 1'b0;
    if (!en_d)                 state_d = DISARMED;
    else if (snz_d)            state_d = SNOOZING;
    else                       state_d = ARMED;
  end

  // Register file, pending flag, snapshot and match counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      ie_q      <= 1'b0;
      mask_q    <= '0;
      oneshot_q <= 1'b0;
      alarm_q   <= '0;
      snap_q    <= '0;
      pend_q    <= 1'b0;
      count_q   <= '0;
      match_q   <= 1'b0;
    end else begin
      match_q <= match_now;
      if (ctrl_we) begin
        ie_q      <= wdata[1];
        mask_q    <= wdata[6:2];
        oneshot_q <= wdata[7];
      end
      if (alarm_we) alarm_q <= wdata[25:0];
      if (event_c)  snap_q  <= time_now;
      // Set beats W1C clear
      if (event_c | snz_expire) begin
        pend_q <= 1'b1;
      end else if ((status_we & wdata[0]) | snz_cmd) begin
        pend_q <= 1'b0;
      end
      // Clear command beats increment
      if (status_we & wdata[31]) begin
        count_q <= '0;
      end else if ((event_c | snz_expire) & ~(&count_q)) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign irq = pend_q & ie_q;

  // Read mux
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL:   rdata[15:0] = {snooze_q, oneshot_q, mask_q, ie_q, en};
      REG_ALARM:  rdata[25:0] = alarm_q;
      REG_STATUS: begin
        rdata[0]          = pend_q;
        rdata[1]          = snoozing;
        rdata[8 +: CNT_W] = count_q;
      end
      REG_SNAP:   rdata[25:0] = snap_q;
      default:    rdata = '0;
    endcase
  end

  assign unused_ok = ^{addr[31:4], addr[1:0], wdata};

endmodule

// File: tb/tb_rtc_alarm.sv
// Self-checking bench for rtc_alarm: directed scenarios plus a randomized run
// against a register-level reference model.
module tb_rtc_alarm;

`ifdef RTC_ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif
  localparam int CNT_MAX = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic [5:0]  t_sec = '0, t_min = '0;
  logic [4:0]  t_hour = '0, t_day = '0;
  logic [3:0]  t_month = '0;
  logic        irq;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic        m_en, m_ie, m_oneshot, m_pend, m_snz, m_prev;
  logic [4:0]  m_mask;
  logic [7:0]  m_snooze, m_snzcnt;
  logic [25:0] m_alarm, m_snap;
  logic [5:0]  m_prevsec;
  int          m_cnt;

  always #10 clk = ~clk;

  rtc_alarm dut (
    .clk(clk), .reset(reset), .cs(cs), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .sec(t_sec), .min(t_min), .hour(t_hour), .day(t_day),
    .month(t_month), .irq(irq)
  );

  task automatic model_reset();
    m_en = 0; m_ie = 0; m_oneshot = 0; m_pend = 0; m_snz = 0; m_prev = 0;
    m_mask = '0; m_snooze = '0; m_snzcnt = '0; m_alarm = '0; m_snap = '0;
    m_prevsec = '0; m_cnt = 0;
  endtask

  // One clock edge of the alarm peripheral, applied to the model
  task automatic model_step();
    logic bw, mt, ev, sec_tick, snz_ok, expire, new_en, new_snz;
    logic [1:0] a;
    bw = cs & wr;
    a  = addr[3:2];
    mt = m_en && (m_mask != 5'd0);
    if (m_mask[0] && t_sec   != m_alarm[5:0])   mt = 0;
    if (m_mask[1] && t_min   != m_alarm[11:6])  mt = 0;
    if (m_mask[2] && t_hour  != m_alarm[16:12]) mt = 0;
    if (m_mask[3] && t_day   != m_alarm[21:17]) mt = 0;
    if (m_mask[4] && t_month != m_alarm[25:22]) mt = 0;
    ev       = mt && !m_prev;
    sec_tick = (t_sec != m_prevsec);
    snz_ok   = SNZ && bw && a == 2'd2 && wdata[2] && m_pend && m_snooze != 8'd0 && m_en && !ev;
    expire   = SNZ && m_snz && sec_tick && m_snzcnt == 8'd1;

    new_en = m_en;
    if (ev && m_oneshot) new_en = 0;
    if (bw && a == 2'd0) new_en = wdata[0];
    new_snz = m_snz;
    if (snz_ok) new_snz = 1;
    if (expire || ev) new_snz = 0;
    if (!new_en) new_snz = 0;

    if (snz_ok) m_snzcnt = m_snooze;
    else if (m_snz && sec_tick && m_snzcnt != 8'd0) m_snzcnt = m_snzcnt - 8'd1;

    if (bw && a == 2'd2 && wdata[0]) m_pend = 0;
    if (snz_ok) m_pend = 0;
    if (expire || ev) m_pend = 1;

    if (bw && a == 2'd2 && wdata[31]) m_cnt = 0;
    else if ((ev || expire) && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;

    if (ev) m_snap = {t_month, t_day, t_hour, t_min, t_sec};
    if (bw && a == 2'd0) begin
      m_ie = wdata[1]; m_mask = wdata[6:2]; m_oneshot = wdata[7];
      m_snooze = SNZ ? wdata[15:8] : 8'd0;
    end
    if (bw && a == 2'd1) m_alarm = wdata[25:0];
    m_prev = mt; m_prevsec = t_sec; m_en = new_en; m_snz = new_snz;
  endtask

  function automatic logic [31:0] exp_reg(input int r);
    case (r)
      0:       return {16'h0, m_snooze, m_oneshot, m_mask, m_ie, m_en};
      1:       return 32'(m_alarm);
      2:       return (32'(m_cnt) << 8) | (32'(m_snz) << 1) | 32'(m_pend);
      default: return 32'(m_snap);
    endcase
  endfunction

  // One bus cycle; address upper/lower bits are randomized to exercise decode
  task automatic tick(input logic c, input logic w, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] rr;
    rr = $urandom();
    cs = c; wr = w; addr = {rr[31:4], a, rr[1:0]}; wdata = d;
    @(posedge clk);
    model_step();
    #1;
    cs = 0; wr = 0;
  endtask

  task automatic reset_tick();
    reset = 0;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1;
  endtask

  task automatic read_reg(input int r, output logic [31:0] d);
    logic [31:0] rr;
    rr = $urandom();
    addr = {rr[31:4], 2'(r), rr[1:0]};
    #1;
    d = rdata;
  endtask

  task automatic set_time(input int mo, input int dy, input int h, input int mi, input int s);
    t_month = 4'(mo); t_day = 5'(dy); t_hour = 5'(h); t_min = 6'(mi); t_sec = 6'(s);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    set_time(0, 0, 0, 0, 0);
    reset_tick();
    for (int r = 0; r < 4; r++) begin
      read_reg(r, d);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL reset_init reg%0d got=%h exp=%h", r, d, 32'h0); end
    end
    tick(1, 1, 2'd1, 32'h0);
    tick(1, 1, 2'd0, 32'h7);
    tick(0, 0, 2'd0, 32'h0);
    read_reg(2, d);
    checks++;
    if (d !== 32'h101) begin failures++; $display("FAIL reset_pre_status got=%h exp=%h", d, 32'h101); end
    reset_tick();
    for (int r = 0; r < 4; r++) begin
      read_reg(r, d);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL reset_mid reg%0d got=%h exp=%h", r, d, 32'h0); end
    end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
  endtask

  task automatic test_basic_match();
    logic [31:0] d;
    reset_tick();
    set_time(3, 7, 12, 29, 59);
    tick(1, 1, 2'd1, (32'd12 << 12) | (32'd30 << 6));
    tick(1, 1, 2'd0, 32'h1F);
    tick(0, 0, 2'd0, 32'h0);
    read_reg(2, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL basic_nomatch got=%h exp=%h", d, 32'h0); end
    set_time(3, 7, 12, 30, 0);
    tick(0, 0, 2'd0, 32'h0);
    read_reg(2, d);
    checks++;
    if (d !== 32'h101) begin failures++; $display("FAIL basic_status got=%h exp=%h", d, 32'h101); end
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL basic_irq got=%b exp=1", irq); end
    read_reg(3, d);
    checks++;
    if (d !== ((32'd3 << 22) | (32'd7 << 17) | (32'd12 << 12) | (32'd30 << 6))) begin
      failures++; $display("FAIL basic_snap got=%h exp=%h", d, (32'd3 << 22) | (32'd7 << 17) | (32'd12 << 12) | (32'd30 << 6));
    end
    for (int i = 0; i < 10; i++) tick(0, 0, 2'd0, 32'h0);
    read_reg(2, d);
    checks++;
    if (d !== 32'h101) begin failures++; $display("FAIL basic_hold got=%h exp=%h", d, 32'h101); end
    for (int r = 0; r < 4; r++) begin
      read_reg(r, d);
      checks++;
      if (d !== exp_reg(r)) begin failures++; $display("FAIL basic_model reg%0d got=%h exp=%h", r, d, exp_reg(r)); end
    end
  endtask

  task automatic test_w1c_priority();
    logic [31:0] d;
    set_time(3, 7, 12, 30, 1);
    tick(0, 0, 2'd0, 32'h0);
    set_time(3, 7, 12, 30, 0);
    tick(1, 1, 2'd2, 32'h1);
    read_reg(2, d);
    checks++;
    if (d !== 32'h201) begin failures++; $display("FAIL w1c_on_event got=%h exp=%h", d, 32'h201); end
    tick(1, 1, 2'd2, 32'h1);
    read_reg(2, d);
    checks++;
    if (d !== 32'h200) begin failures++; $display("FAIL w1c_clear got=%h exp=%h", d, 32'h200); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL w1c_irq got=%b exp=0", irq); end
  endtask

  task automatic test_oneshot_mask();
    logic [31:0] d;
    tick(1, 1, 2'd0, 32'h9F);
    set_time(3, 7, 12, 30, 1);
    tick(0, 0, 2'd0, 32'h0);
    set_time(3, 7, 12, 30, 0);
    tick(0, 0, 2'd0, 32'h0);
    read_reg(0, d);
    checks++;
    if (d !== 32'h9E) begin failures++; $display("FAIL oneshot_ctrl got=%h exp=%h", d, 32'h9E); end
    read_reg(2, d);
    checks++;
    if (d !== 32'h301) begin failures++; $display("FAIL oneshot_status got=%h exp=%h", d, 32'h301); end
    tick(1, 1, 2'd2, 32'h1);
    set_time(3, 7, 12, 30, 1);
    tick(0, 0, 2'd0, 32'h0);
    set_time(3, 7, 12, 30, 0);
    tick(0, 0, 2'd0, 32'h0);
    tick(0, 0, 2'd0, 32'h0);
    read_reg(2, d);
    checks++;
    if (d !== 32'h300) begin failures++; $display("FAIL oneshot_rearm got=%h exp=%h", d, 32'h300); end
    tick(1, 1, 2'd0, 32'h03);
    set_time(3, 7, 12, 30, 1);
    tick(0, 0, 2'd0, 32'h0);
    set_time(3, 7, 12, 30, 0);
    tick(0, 0, 2'd0, 32'h0);
    tick(0, 0, 2'd0, 32'h0);
    read_reg(2, d);
    checks++;
    if (d !== 32'h300) begin failures++; $display("FAIL mask_zero got=%h exp=%h", d, 32'h300); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL mask_zero_irq got=%b exp=0", irq); end
  endtask

  task automatic test_count_sat();
    logic [31:0] d;
    set_time(3, 7, 12, 30, 1);
    tick(1, 1, 2'd0, 32'h1F);
    tick(1, 1, 2'd2, 32'h8000_0000);
    read_reg(2, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL cnt_clear got=%h exp=%h", d, 32'h0); end
    for (int i = 0; i < 256; i++) begin
      set_time(3, 7, 12, 30, 0); tick(0, 0, 2'd0, 32'h0);
      set_time(3, 7, 12, 30, 1); tick(0, 0, 2'd0, 32'h0);
    end
    read_reg(2, d);
    checks++;
    if (d !== 32'hFF01) begin failures++; $display("FAIL cnt_sat got=%h exp=%h", d, 32'hFF01); end
    set_time(3, 7, 12, 30, 0); tick(0, 0, 2'd0, 32'h0);
    read_reg(2, d);
    checks++;
    if (d !== 32'hFF01) begin failures++; $display("FAIL cnt_sat_hold got=%h exp=%h", d, 32'hFF01); end
    set_time(3, 7, 12, 30, 1); tick(0, 0, 2'd0, 32'h0);
    set_time(3, 7, 12, 30, 0); tick(1, 1, 2'd2, 32'h8000_0000);
    read_reg(2, d);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL cnt_clr_vs_event got=%h exp=%h", d, 32'h1); end
    for (int r = 0; r < 4; r++) begin
      read_reg(r, d);
      checks++;
      if (d !== exp_reg(r)) begin failures++; $display("FAIL cnt_model reg%0d got=%h exp=%h", r, d, exp_reg(r)); end
    end
  endtask

`ifdef RTC_ALARM_SNOOZE_EN
  task automatic test_snooze();
    logic [31:0] d, snap0;
    tick(1, 1, 2'd0, 32'h31F);
    read_reg(0, d);
    checks++;
    if (d !== 32'h31F) begin failures++; $display("FAIL snz_ctrl got=%h exp=%h", d, 32'h31F); end
    read_reg(3, snap0);
    tick(1, 1, 2'd2, 32'h4);
    read_reg(2, d);
    checks++;
    if (d !== 32'h002) begin failures++; $display("FAIL snz_start got=%h exp=%h", d, 32'h002); end
    set_time(3, 7, 12, 30, 1); tick(0, 0, 2'd0, 32'h0);
    set_time(3, 7, 12, 30, 2); tick(0, 0, 2'd0, 32'h0);
    read_reg(2, d);
    checks++;
    if (d !== 32'h002) begin failures++; $display("FAIL snz_two_ticks got=%h exp=%h", d, 32'h002); end
    set_time(3, 7, 12, 30, 3); tick(0, 0, 2'd0, 32'h0);
    read_reg(2, d);
    checks++;
    if (d !== 32'h101) begin failures++; $display("FAIL snz_expire got=%h exp=%h", d, 32'h101); end
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL snz_irq got=%b exp=1", irq); end
    read_reg(3, d);
    checks++;
    if (d !== snap0) begin failures++; $display("FAIL snz_snap got=%h exp=%h", d, snap0); end
    set_time(3, 7, 12, 30, 0); tick(0, 0, 2'd0, 32'h0);
    tick(1, 1, 2'd2, 32'h4);
    read_reg(2, d);
    checks++;
    if (d !== 32'h202) begin failures++; $display("FAIL snz_restart got=%h exp=%h", d, 32'h202); end
    set_time(3, 7, 12, 30, 1); tick(0, 0, 2'd0, 32'h0);
    set_time(3, 7, 12, 30, 0); tick(0, 0, 2'd0, 32'h0);
    read_reg(2, d);
    checks++;
    if (d !== 32'h301) begin failures++; $display("FAIL snz_event_ends got=%h exp=%h", d, 32'h301); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] d, w;
    int op;
    reset_tick();
    for (int i = 0; i < 3000; i++) begin
      set_time($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom_range(0, 3));
      op = $urandom_range(0, 11);
      w  = $urandom();
      if ($urandom_range(0, 199) == 0) begin
        reset_tick();
      end else begin
        case (op)
          0, 1: begin
            w[0] = ($urandom_range(0, 3) != 0);
            w[15:8] = 8'($urandom_range(0, 4));
            tick(1, 1, 2'd0, w);
          end
          2: begin
            w = {6'h0, 4'($urandom_range(0, 1)), 5'($urandom_range(0, 1)), 5'($urandom_range(0, 1)),
                 6'($urandom_range(0, 1)), 6'($urandom_range(0, 1))};
            tick(1, 1, 2'd1, w);
          end
          3: tick(1, 1, 2'd2, w & 32'h8000_0005);
          4: tick(1, 1, 2'd3, w);
          5: tick(1, 0, 2'($urandom_range(0, 3)), w);
          6: tick(0, 1, 2'($urandom_range(0, 3)), w);
          default: tick(0, 0, 2'd0, 32'h0);
        endcase
      end
      for (int r = 0; r < 4; r++) begin
        read_reg(r, d);
        checks++;
        if (d !== exp_reg(r)) begin
          failures++; $display("FAIL random_reg%0d cycle=%0d got=%h exp=%h", r, i, d, exp_reg(r));
        end
      end
      checks++;
      if (irq !== (m_pend & m_ie)) begin
        failures++; $display("FAIL random_irq cycle=%0d got=%b exp=%b", i, irq, m_pend & m_ie);
      end
    end
  endtask

  initial begin
    model_reset();
    #5;
    test_reset();
    test_basic_match();
    test_w1c_priority();
    test_oneshot_mask();
    test_count_sat();
`ifdef RTC_ALARM_SNOOZE_EN
    test_snooze();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
